// File: rtl/jtag_arbiter.sv
// Round-robin arbiter sharing one JTAG shift engine and its instruction/data FIFOs among NUM_REQ requesters.
// Optional busy-rise watchdog enabled by defining JTAG_ARB_TIMEOUT_EN.
module jtag_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int DATA_INSTRUCTION = 6,
    parameter int DATA_FIFO        = 8,
    parameter int BUSY_TIMEOUT     = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  go,
    input  logic [NUM_REQ-1:0]                  req_op,
    input  logic [NUM_REQ*8-1:0]                req_len,
    input  logic [NUM_REQ-1:0]                  req_conf,
    input  logic [NUM_REQ-1:0]                  req_end,
    input  logic [NUM_REQ-1:0]                  req_wr_instruction,
    input  logic [NUM_REQ*DATA_INSTRUCTION-1:0] req_wdata_instr,
    input  logic [NUM_REQ-1:0]                  req_wr_data,
    input  logic [NUM_REQ*DATA_FIFO-1:0]        req_wdata_data,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [NUM_REQ-1:0]                  done,
    output logic                                err,
    output logic                                wr_instruction,
    output logic [DATA_INSTRUCTION-1:0]         wdata_instruction,
    output logic                                wr_data,
    output logic [DATA_FIFO-1:0]                wdata_data,
    input  logic                                full_instruction,
    input  logic                                full_data,
    output logic [NUM_REQ-1:0]                  req_full_instruction,
    output logic [NUM_REQ-1:0]                  req_full_data,
    output logic                                work,
    output logic                                op,
    output logic                                conf_op,
    output logic                                end_op,
    output logic [7:0]                          len,
    input  logic                                busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, OWN, LAUNCH, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  ptr_next;
    logic [IDX_W-1:0]  pick;
    logic              found;
    int                scan_idx;
    logic              sel_go, sel_req, sel_op, sel_conf, sel_end;
    logic [7:0]        sel_len;

    logic [NUM_REQ-1:0][DATA_INSTRUCTION-1:0] instr_masked;
    logic [NUM_REQ-1:0][DATA_FIFO-1:0]        data_masked;

    // FIFO write path is purely combinational; only the granted slice reaches the FIFOs.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign instr_masked[gi] = grant[gi] ? req_wdata_instr[gi*DATA_INSTRUCTION +: DATA_INSTRUCTION] : '0;
            assign data_masked[gi]  = grant[gi] ? req_wdata_data[gi*DATA_FIFO +: DATA_FIFO] : '0;
        end
    endgenerate

    always_comb begin
        wdata_instruction = '0;
        wdata_data        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wdata_instruction = wdata_instruction | instr_masked[i];
            wdata_data        = wdata_data | data_masked[i];
        end
    end

    assign wr_instruction       = |(req_wr_instruction & grant);
    assign wr_data              = |(req_wr_data & grant);
    assign req_full_instruction = {NUM_REQ{full_instruction}} & grant;
    assign req_full_data        = {NUM_REQ{full_data}} & grant;

    // First active request at or after the round-robin pointer.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = IDX_W'(scan_idx);
            end
        end
    end

    always_comb begin
        sel_go   = 1'b0;
        sel_req  = 1'b0;
        sel_op   = 1'b0;
        sel_conf = 1'b0;
        sel_end  = 1'b0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                sel_go   = go[i];
                sel_req  = req[i];
                sel_op   = req_op[i];
                sel_conf = req_conf[i];
                sel_end  = req_end[i];
                sel_len  = req_len[i*8 +: 8];
            end
        end
    end

    assign ptr_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef JTAG_ARB_TIMEOUT_EN
    // Counter starts at 0 in the first WAIT_HI cycle, so err lands BUSY_TIMEOUT cycles after work.
    localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 2);
    logic [15:0] cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            done    <= '0;
            err     <= 1'b0;
            work    <= 1'b0;
            op      <= 1'b0;
            len     <= '0;
            conf_op <= 1'b0;
            end_op  <= 1'b0;
            ptr     <= '0;
            owner   <= '0;
`ifdef JTAG_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            work <= 1'b0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    end_op <= 1'b0;
                    if (!busy && found) begin
                        grant <= NUM_REQ'(1) << pick;
                        owner <= pick;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (sel_go) begin
                        op      <= sel_op;
                        len     <= sel_len;
                        conf_op <= sel_conf;
                        end_op  <= sel_end;
                        work    <= 1'b1;
                        state   <= LAUNCH;
                    end else if (!sel_req) begin
                        grant <= '0;
                        ptr   <= ptr_next;
                        state <= IDLE;
                    end
                end
                LAUNCH: begin
`ifdef JTAG_ARB_TIMEOUT_EN
                    cnt <= '0;
`endif
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (busy) begin
                        state <= WAIT_LO;
`ifdef JTAG_ARB_TIMEOUT_EN
                    end else if (cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        done  <= grant;
                        grant <= '0;
                        ptr   <= ptr_next;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
`endif
                    end
                end
                WAIT_LO: begin
                    if (!busy) begin
                        done  <= grant;
                        grant <= '0;
                        ptr   <= ptr_next;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_arbiter.sv
// Randomized self-checking bench for jtag_arbiter against a transaction-level round-robin model.
module tb_jtag_arbiter;
    localparam int N  = 2;
    localparam int DI = 6;
    localparam int DF = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, go, req_op, req_conf, req_end, req_wr_instruction, req_wr_data;
    logic [N*8-1:0]  req_len;
    logic [N*DI-1:0] req_wdata_instr;
    logic [N*DF-1:0] req_wdata_data;
    logic [N-1:0]    grant, done, req_full_instruction, req_full_data;
    logic            err, wr_instruction, wr_data, full_instruction, full_data;
    logic [DI-1:0]   wdata_instruction;
    logic [DF-1:0]   wdata_data;
    logic            work, op, conf_op, end_op, busy;
    logic [7:0]      len;

    int errors = 0;
    int checks = 0;
    int exp_ptr = 0;

    jtag_arbiter #(.NUM_REQ(N), .DATA_INSTRUCTION(DI), .DATA_FIFO(DF), .BUSY_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .go(go), .req_op(req_op), .req_len(req_len),
        .req_conf(req_conf), .req_end(req_end), .req_wr_instruction(req_wr_instruction),
        .req_wdata_instr(req_wdata_instr), .req_wr_data(req_wr_data), .req_wdata_data(req_wdata_data),
        .grant(grant), .done(done), .err(err), .wr_instruction(wr_instruction),
        .wdata_instruction(wdata_instruction), .wr_data(wr_data), .wdata_data(wdata_data),
        .full_instruction(full_instruction), .full_data(full_data),
        .req_full_instruction(req_full_instruction), .req_full_data(req_full_data),
        .work(work), .op(op), .conf_op(conf_op), .end_op(end_op), .len(len), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Round-robin rule: first requester at or after the pointer.
    function automatic int rr_pick(input logic [N-1:0] mask, input int p);
        for (int i = 0; i < N; i++) begin
            if (mask[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic launch(input int w, input logic f_op, input logic [7:0] f_len,
                          input logic f_conf, input logic f_end);
        logic [N-1:0] other_go;
        for (int i = 0; i < N; i++) begin
            req_op[i]        = (i == w) ? f_op : 1'($urandom);
            req_conf[i]      = (i == w) ? f_conf : 1'($urandom);
            req_end[i]       = (i == w) ? f_end : 1'($urandom);
            req_len[i*8 +: 8] = (i == w) ? f_len : 8'($urandom);
        end
        other_go = N'($urandom);
        go = other_go | (N'(1) << w);
        tick();
        go = '0;
        check("work_pulse", 32'(work), 32'd1);
        check("op", 32'(op), 32'(f_op));
        check("len", 32'(len), 32'(f_len));
        check("conf_op", 32'(conf_op), 32'(f_conf));
        check("end_op", 32'(end_op), 32'(f_end));
        tick();
        check("work_single", 32'(work), 32'd0);
    endtask

    // Full ownership cycle: FIFO writes, launch, busy handshake, done.
    task automatic do_txn(input int w);
        int nwr, nidle, nbusy;
        logic [N-1:0] wv, iv, og;
        logic [DF-1:0] dv[N];
        logic [DI-1:0] ivd[N];
        logic f_op, f_conf, f_end;
        logic [7:0] f_len;
        nwr = $urandom_range(1, 4);
        for (int k = 0; k < nwr; k++) begin
            wv = N'($urandom);
            iv = N'($urandom);
            og = N'($urandom) & ~(N'(1) << w);
            for (int i = 0; i < N; i++) begin
                dv[i]  = DF'($urandom);
                ivd[i] = DI'($urandom);
                req_wdata_data[i*DF +: DF]  = dv[i];
                req_wdata_instr[i*DI +: DI] = ivd[i];
            end
            req_wr_data = wv;
            req_wr_instruction = iv;
            go = og;
            full_data = 1'($urandom);
            full_instruction = 1'($urandom);
            #1;
            check("wr_data", 32'(wr_data), 32'(wv[w]));
            check("wdata_data", 32'(wdata_data), 32'(dv[w]));
            check("wr_instruction", 32'(wr_instruction), 32'(iv[w]));
            check("wdata_instruction", 32'(wdata_instruction), 32'(ivd[w]));
            check("req_full_data", 32'(req_full_data), full_data ? 32'(1 << w) : 32'd0);
            check("req_full_instr", 32'(req_full_instruction), full_instruction ? 32'(1 << w) : 32'd0);
            tick();
            check("grant_hold", 32'(grant), 32'(1 << w));
            check("no_work_nonowner_go", 32'(work), 32'd0);
        end
        req_wr_data = '0;
        req_wr_instruction = '0;
        go = '0;
        f_op = 1'($urandom);
        f_conf = 1'($urandom);
        f_end = 1'($urandom);
        f_len = 8'($urandom);
        launch(w, f_op, f_len, f_conf, f_end);
        nidle = $urandom_range(0, 2);
        for (int k = 0; k < nidle; k++) begin
            tick();
            check("wait_hi_done", 32'(done), 32'd0);
        end
        busy = 1'b1;
        nbusy = $urandom_range(1, 5);
        for (int k = 0; k < nbusy; k++) begin
            tick();
            check("busy_done", 32'(done), 32'd0);
            check("busy_grant", 32'(grant), 32'(1 << w));
        end
        busy = 1'b0;
        tick();
        check("done", 32'(done), 32'(1 << w));
        check("grant_clear", 32'(grant), 32'd0);
        check("len_stable", 32'(len), 32'(f_len));
        req[w] = 1'b0;
        tick();
        check("done_single", 32'(done), 32'd0);
        exp_ptr = (w + 1) % N;
    endtask

    initial begin
        logic [N-1:0] mask;
        int w;
        rst = 1'b1;
        req = '0; go = '0; req_op = '0; req_len = '0; req_conf = '0; req_end = '0;
        req_wr_instruction = '0; req_wdata_instr = '0; req_wr_data = '0; req_wdata_data = '0;
        full_instruction = 1'b0; full_data = 1'b0; busy = 1'b0;
        tick(); tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_work", 32'(work), 32'd0);
        check("rst_len", 32'(len), 32'd0);
        rst = 1'b0;
        tick();

        for (int round = 0; round < 30; round++) begin
            mask = (round < 3) ? '1 : N'($urandom_range(1, (1 << N) - 1));
            req = mask;
            while (mask != '0) begin
                w = rr_pick(mask, exp_ptr);
                tick();
                check("grant", 32'(grant), 32'(1 << w));
                if (round >= 3 && $urandom_range(0, 3) == 0) begin
                    req[w] = 1'b0;
                    mask[w] = 1'b0;
                    tick();
                    check("drop_grant", 32'(grant), 32'd0);
                    check("drop_work", 32'(work), 32'd0);
                    check("drop_done", 32'(done), 32'd0);
                    exp_ptr = (w + 1) % N;
                end else begin
                    do_txn(w);
                    mask[w] = 1'b0;
                end
            end
            $display("round %0d complete, pointer %0d", round, exp_ptr);
        end

`ifdef JTAG_ARB_TIMEOUT_EN
        w = rr_pick(N'(1), exp_ptr);
        req = N'(1);
        tick();
        check("tmo_grant", 32'(grant), 32'(1 << w));
        launch(w, 1'b1, 8'd32, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("tmo_err_early", 32'(err), 32'd0);
        end
        tick();
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_done", 32'(done), 32'(1 << w));
        check("tmo_grant_clear", 32'(grant), 32'd0);
        req = '0;
        tick();
        check("tmo_err_single", 32'(err), 32'd0);
        exp_ptr = (w + 1) % N;
`endif

        // Async reset while the engine is busy.
        w = rr_pick(N'(1), exp_ptr);
        req = N'(1);
        tick();
        check("mid_grant", 32'(grant), 32'(1 << w));
        launch(w, 1'b1, 8'd32, 1'b1, 1'b1);
        busy = 1'b1;
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_op", 32'(op), 32'd0);
        check("mid_rst_len", 32'(len), 32'd0);
        check("mid_rst_conf", 32'(conf_op), 32'd0);
        check("mid_rst_end", 32'(end_op), 32'd0);
        check("mid_rst_done_err", 32'({done, err, work}), 32'd0);
        busy = 1'b0;
        tick();
        rst = 1'b0;
        req = '1;
        tick();
        check("post_rst_grant", 32'(grant), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
